// File: rtl/match_judge_pkg.sv
// Shared encodings for the match judge and display-side consumers.
package match_judge_pkg;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_JUDGE = 3'd3,
    ST_SHOW  = 3'd4
  } state_t;

endpackage

// File: rtl/match_judge_blink_timer.sv
// Result blink generator: square wave while en is high, held at 1 otherwise.
module blink_timer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int FLASH_HZ = 2
) (
  input  logic sclk,
  input  logic rst,
  input  logic en,
  output logic flash
);

  localparam int          DIV   = (CLK_FREQ / (2 * FLASH_HZ) > 0) ? CLK_FREQ / (2 * FLASH_HZ) : 1;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             flash_q;

  // Divider and toggle flop; both park in their start values while disabled
  always_ff @(posedge sclk) begin
    if (rst || !en) begin
      div_q   <= '0;
      flash_q <= 1'b1;
    end else if (div_q == DIV_W'(DIV - 1)) begin
      div_q   <= '0;
      flash_q <= ~flash_q;
    end else begin
      div_q   <= div_q + 1'b1;
    end
  end

  // Outside the enabled window the display is never blanked
  always_comb begin
    flash = flash_q | ~en;
  end

endmodule

// File: rtl/match_judge.sv
// Round judge: tracks countdown phases, decides the winner and keeps the best score.
module match_judge
  import match_judge_pkg::*;
#(
  parameter int CNT_W    = 7,
  parameter int CLK_FREQ = 50_000_000,
  parameter int FLASH_HZ = 2
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             is_counting,
  input  logic [CNT_W-1:0] down_cnt,
  input  logic [CNT_W-1:0] cnt_1,
  input  logic [CNT_W-1:0] cnt_2,
  input  logic             clr,
  output logic [1:0]       winner,
  output logic             result_valid,
  output logic [CNT_W-1:0] best_score,
  output logic             new_record,
  output logic             flash
);

  state_t           state_q, state_d;
  logic             counting_q;
  logic             rise, fall;
  winner_t          win_q;
  logic             valid_q, record_q;
  logic [CNT_W-1:0] best_q;
  logic [CNT_W-1:0] top_cnt;

  // Single input register for is_counting edge detection
  always_ff @(posedge sclk) begin
    if (rst) counting_q <= 1'b0;
    else     counting_q <= is_counting;
  end

  // Edges and the higher of the two player counts
  always_comb begin
    rise    = is_counting & ~counting_q;
    fall    = ~is_counting & counting_q;
    top_cnt = (cnt_1 > cnt_2) ? cnt_1 : cnt_2;
  end

  // State register
  always_ff @(posedge sclk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a rise in SHOW takes priority over clr
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (rise) state_d = ST_RUN;
      ST_RUN:   if (fall) state_d = (down_cnt == '0) ? ST_JUDGE : ST_PAUSE;
      ST_PAUSE: if (rise) state_d = ST_RUN;
      ST_JUDGE: state_d = ST_SHOW;
      ST_SHOW: begin
        if (rise)     state_d = ST_RUN;
        else if (clr) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Result registers: latched when leaving JUDGE, cleared on entry to RUN or IDLE
  always_ff @(posedge sclk) begin
    if (rst) begin
      win_q    <= WIN_NONE;
      valid_q  <= 1'b0;
      record_q <= 1'b0;
      best_q   <= '0;
    end else if (state_q == ST_JUDGE) begin
      valid_q <= 1'b1;
      if (cnt_1 > cnt_2)      win_q <= WIN_P1;
      else if (cnt_2 > cnt_1) win_q <= WIN_P2;
      else                    win_q <= WIN_TIE;
      if (top_cnt > best_q) begin
        best_q   <= top_cnt;
        record_q <= 1'b1;
      end else begin
        record_q <= 1'b0;
      end
    end else if (state_d == ST_RUN || state_d == ST_IDLE) begin
      win_q    <= WIN_NONE;
      valid_q  <= 1'b0;
      record_q <= 1'b0;
    end
  end

  blink_timer #(
    .CLK_FREQ(CLK_FREQ),
    .FLASH_HZ(FLASH_HZ)
  ) u_blink (
    .sclk (sclk),
    .rst  (rst),
    .en   (state_q == ST_SHOW),
    .flash(flash)
  );

  // Output mapping
  always_comb begin
    winner       = win_q;
    result_valid = valid_q;
    new_record   = record_q;
    best_score   = best_q;
  end

endmodule

// File: tb/tb_match_judge.sv
// Self-checking bench for match_judge: directed scenarios then randomized rounds.
module tb_match_judge;

  localparam int CW = 7;

  logic          sclk = 1'b0;
  logic          rst, is_counting, clr;
  logic [CW-1:0] down_cnt, cnt_1, cnt_2;
  logic [1:0]    winner;
  logic          result_valid, new_record, flash;
  logic [CW-1:0] best_score;

  int n_cmp = 0;
  int n_err = 0;
  // Round-level reference model of the visible result
  int exp_win, exp_val, exp_rec, exp_best;
  bit in_show;

  match_judge #(
    .CNT_W   (CW),
    .CLK_FREQ(40),
    .FLASH_HZ(2)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .is_counting (is_counting),
    .down_cnt    (down_cnt),
    .cnt_1       (cnt_1),
    .cnt_2       (cnt_2),
    .clr         (clr),
    .winner      (winner),
    .result_valid(result_valid),
    .best_score  (best_score),
    .new_record  (new_record),
    .flash       (flash)
  );

  always #5 sclk = ~sclk;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".winner"}, int'(winner), exp_win);
    chk({tag, ".valid"}, int'(result_valid), exp_val);
    chk({tag, ".record"}, int'(new_record), exp_rec);
    chk({tag, ".best"}, int'(best_score), exp_best);
  endtask

  task automatic model_clear();
    exp_win = 0; exp_val = 0; exp_rec = 0;
  endtask

  task automatic model_reset();
    model_clear();
    exp_best = 0;
    in_show  = 0;
  endtask

  task automatic start_run(input bit with_clr);
    is_counting = 1'b1;
    clr = with_clr;
    step();
    clr = 1'b0;
    model_clear();
    in_show = 0;
    chk_out("run_entry");
    chk("run_entry.flash", int'(flash), 1);
  endtask

  task automatic end_run(input int c1, input int c2, input int d);
    int top;
    cnt_1 = CW'(c1); cnt_2 = CW'(c2); down_cnt = CW'(d);
    is_counting = 1'b0;
    step();
    chk("judge_gap.valid", int'(result_valid), 0);
    step();
    if (d == 0) begin
      exp_win = (c1 > c2) ? 1 : (c2 > c1) ? 2 : 3;
      top = (c1 > c2) ? c1 : c2;
      if (top > exp_best) begin
        exp_best = top; exp_rec = 1;
      end else begin
        exp_rec = 0;
      end
      exp_val = 1;
      in_show = 1;
    end
    chk_out(d == 0 ? "result" : "pause");
    chk("first.flash", int'(flash), 1);
  endtask

  // Observe n SHOW cycles (cycle 0 already seen at the end of end_run)
  task automatic show_dwell(input int n);
    for (int k = 1; k < n; k++) begin
      step();
      chk("show.flash", int'(flash), ((k / 10) % 2 == 0) ? 1 : 0);
    end
  endtask

  task automatic clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
    in_show = 0;
    chk_out("clear");
    chk("clear.flash", int'(flash), 1);
  endtask

  initial begin
    int c1, c2, d;
    rst = 1'b1; is_counting = 1'b0; clr = 1'b0;
    down_cnt = '0; cnt_1 = '0; cnt_2 = '0;
    model_reset();
    step(); step();
    rst = 1'b0;
    chk_out("reset");
    chk("reset.flash", int'(flash), 1);

    // clr in IDLE is ignored
    clr = 1'b1; step(); clr = 1'b0;
    chk_out("idle_clr");

    // Round 1: P1 wins with a new record
    start_run(0);
    step(); step();
    end_run(12, 7, 0);
    show_dwell(3);
    clear();

    // Round 2: P2 wins, no record
    start_run(0);
    end_run(5, 9, 0);
    // Leave SHOW directly on a rise, then pause mid-countdown
    start_run(0);
    end_run(1, 1, 8);
    step();
    chk("pause_hold.valid", int'(result_valid), 0);
    start_run(0);
    end_run(20, 20, 0);
    show_dwell(40);
    clear();

    // Simultaneous clr and rise in SHOW, then clr in RUN ignored
    start_run(0);
    end_run(2, 3, 0);
    start_run(1);
    clr = 1'b1; step(); clr = 1'b0;
    chk_out("run_clr");
    end_run(19, 4, 0);

    // Reset while showing
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    chk_out("rst_show");
    chk("rst_show.flash", int'(flash), 1);

    // Boundaries: 0/0 tie with zero best, full-scale counts
    start_run(0);
    end_run(0, 0, 0);
    clear();
    start_run(0);
    end_run(127, 126, 0);
    start_run(0);
    end_run(127, 127, 0);

    // Reset mid-RUN discards the pending judgement
    start_run(0);
    cnt_1 = 7'd50; cnt_2 = 7'd10; down_cnt = '0;
    rst = 1'b1; is_counting = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    step(); step();
    chk_out("rst_run");

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      if (in_show) begin
        case ($urandom_range(0, 2))
          0: begin clear(); start_run(0); end
          1: start_run(1);
          default: start_run(0);
        endcase
      end else begin
        start_run(0);
      end
      for (int k = $urandom_range(0, 4); k > 0; k--) begin
        clr = ($urandom_range(0, 3) == 0);
        step();
        clr = 1'b0;
        chk_out("rand_run");
      end
      c1 = $urandom_range(0, 127);
      c2 = ($urandom_range(0, 4) == 0) ? c1 : $urandom_range(0, 127);
      d  = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 127);
      end_run(c1, c2, d);
      if (d == 0) show_dwell($urandom_range(1, 25));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/match_judge.md
MATCH_JUDGE -- requirements
Module: match_judge

Interface
REQ-001 The block SHALL have parameter CNT_W, default 7, giving the counter value width.
REQ-002 The block SHALL have parameter CLK_FREQ, default 50_000_000, giving the sclk frequency in Hz.
REQ-003 The block SHALL have parameter FLASH_HZ, default 2, giving the result blink rate in Hz.
REQ-004 sclk  input  1  Sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  Reset, synchronous, active-high.
REQ-006 is_counting  input  1  High while the countdown is running.
REQ-007 down_cnt  input  CNT_W  Current countdown value.
REQ-008 cnt_1  input  CNT_W  Player 1 press count.
REQ-009 cnt_2  input  CNT_W  Player 2 press count.
REQ-010 clr  input  1  Debounced one-cycle pulse that clears the shown result.
REQ-011 winner  output  2  Result code: NONE, P1, P2 or TIE.
REQ-012 result_valid  output  1  High while a judged result is held.
REQ-013 best_score  output  CNT_W  Highest single-player count since reset.
REQ-014 new_record  output  1  High while the held result set a new best_score.
REQ-015 flash  output  1  Blink enable to the display; square wave at FLASH_HZ in SHOW, else 1.

Function
REQ-016 The block SHALL register is_counting once and detect rise and fall edges from the registered copy.
REQ-017 The FSM SHALL have states IDLE, RUN, PAUSE, JUDGE and SHOW.
REQ-018 IDLE->RUN, PAUSE->RUN and SHOW->RUN SHALL occur on a rise of is_counting.
REQ-019 RUN->JUDGE SHALL occur on a fall of is_counting when down_cnt==0; RUN->PAUSE on a fall when down_cnt!=0.
REQ-020 JUDGE SHALL last exactly one cycle and always go to SHOW.
REQ-021 In JUDGE, the block SHALL latch winner = P1 if cnt_1>cnt_2, P2 if cnt_2>cnt_1, TIE if equal (including 0/0).
REQ-022 In JUDGE, if max(cnt_1,cnt_2) > best_score, best_score SHALL take that max and new_record SHALL be set; otherwise both SHALL hold, with new_record cleared.
REQ-023 Comparisons SHALL be unsigned at CNT_W bits; no saturation logic beyond input width.
REQ-024 result_valid SHALL rise on the first SHOW cycle, i.e. 2 cycles after the is_counting fall reaches the input register.
REQ-025 SHOW->IDLE SHALL occur on clr; winner returns to NONE and result_valid and new_record clear in the next cycle; best_score holds.
REQ-026 clr SHALL be ignored in IDLE, RUN, PAUSE and JUDGE.
REQ-027 Simultaneous clr and is_counting rise in SHOW SHALL go to RUN, with the result cleared as for clr.
REQ-028 Entering RUN SHALL clear winner, result_valid and new_record.
REQ-029 flash SHALL toggle every CLK_FREQ/(2*FLASH_HZ) cycles while in SHOW, starting high with a zeroed divider on SHOW entry.
REQ-030 flash SHALL be forced to 1 outside SHOW.
REQ-031 The blink divider SHALL wrap to 0 at its terminal count; no other counter SHALL wrap.

Reset
REQ-032 On rst, the state SHALL be IDLE and winner=NONE, result_valid=0, new_record=0, best_score=0, flash=1, divider=0, and the edge register=0.
REQ-033 rst asserted mid-RUN or mid-SHOW SHALL take effect on the next edge and discard any pending judgement.

Structure
REQ-034 Winner codes (NONE=00, P1=01, P2=10, TIE=11) and FSM state encodings SHALL reside in a shared package/include used by display-side consumers.
REQ-035 The blink divider SHALL be one sub-module, blink_timer (inputs sclk, rst, en; output flash), with the divider reset while en is low.

Verification
REQ-036 The bench SHALL use CLK_FREQ=40 and FLASH_HZ=2 so that flash toggles every 10 cycles.
REQ-037 Scenario: is_counting 1->0 with down_cnt=0, cnt_1=12, cnt_2=7 -> winner=P1, result_valid=1, best_score=12, new_record=1.
REQ-038 Scenario: second round ends with cnt_1=5, cnt_2=9 -> winner=P2, best_score stays 12, new_record=0.
REQ-039 Scenario: is_counting falls with down_cnt=8 -> PAUSE, result_valid stays 0; rise then fall at 0 with cnt 20/20 -> winner=TIE, best_score=20.
REQ-040 Scenario: in SHOW, observe flash for 40 cycles -> 1 for 10, 0 for 10, repeating; then clr -> result_valid=0, flash=1, best_score=20.
REQ-041 Scenario: clr and is_counting rise in the same cycle in SHOW -> state RUN, winner=NONE; clr pulse in RUN -> no effect.
REQ-042 Scenario: rst pulse in SHOW with best_score=20 -> all outputs at reset values the next cycle, best_score=0.
